// File: rtl/hart_bus_arb.sv
// Round-robin arbiter sharing one memory bus among N_HARTS harts, with
// write-invalidate broadcast and a single AMO lock.
module hart_bus_arb #(
   parameter int N_HARTS = 2,
   parameter int LINE_W  = 512
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_HARTS*64-1:0]     h_addr,
   input  logic [N_HARTS-1:0]        h_rd,
   input  logic [N_HARTS-1:0]        h_wr,
   input  logic [N_HARTS*LINE_W-1:0] h_data_out,
   output logic [LINE_W-1:0]         h_data_in,
   output logic [N_HARTS-1:0]        h_dv,
   output logic [63:0]               h_inv_addr,
   output logic [N_HARTS-1:0]        h_inv,
   input  logic [N_HARTS-1:0]        h_amo_req,
   output logic [N_HARTS-1:0]        h_amo_ack,
   output logic [63:0]               m_addr,
   output logic                      m_rd,
   output logic                      m_wr,
   output logic [LINE_W-1:0]         m_data_out,
   input  logic [LINE_W-1:0]         m_data_in,
   input  logic                      m_dv,
   output logic [1:0]                dbg_state_o
);

   localparam int IW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_DONE = 2'd3} state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       g_q, g_d;
   logic [IW-1:0]       rr_q, rr_d;
   logic [63:0]         m_addr_q, m_addr_d;
   logic [LINE_W-1:0]   m_data_q, m_data_d;
   logic                m_rd_q, m_rd_d;
   logic                m_wr_q, m_wr_d;
   logic                wr_op_q, wr_op_d;
   logic [63:0]         inv_addr_q, inv_addr_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic                lock_vld_q, lock_vld_d;
   logic [IW-1:0]       lock_idx_q, lock_idx_d;

   logic [N_HARTS-1:0]  req_m;
   logic                found;
   logic [IW-1:0]       grant;
   logic [63:0]         sel_addr;
   logic [LINE_W-1:0]   sel_data;
   logic [IW-1:0]       amo_low;
   logic [N_HARTS-1:0]  one_hot_base;

   assign one_hot_base = {{(N_HARTS-1){1'b0}}, 1'b1};

   // Lock mask uses the registered owner, so a same-cycle acquisition does not
   // block the grant made in that cycle.
   always_comb begin
      int idx;
      req_m = h_rd | h_wr;
      if (lock_vld_q) req_m = req_m & (one_hot_base << lock_idx_q);
      found = 1'b0;
      grant = rr_q;
      for (int k = 0; k < N_HARTS; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= N_HARTS) idx = idx - N_HARTS;
         if (!found && req_m[idx]) begin
            found = 1'b1;
            grant = IW'(idx);
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_HARTS; i++) begin
         if (int'(grant) == i) begin
            sel_addr = h_addr[64*i +: 64];
            sel_data = h_data_out[LINE_W*i +: LINE_W];
         end
      end
   end

   always_comb begin
      amo_low = '0;
      for (int i = N_HARTS - 1; i >= 0; i--) begin
         if (h_amo_req[i]) amo_low = IW'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      rr_d       = rr_q;
      m_addr_d   = m_addr_q;
      m_data_d   = m_data_q;
      m_rd_d     = m_rd_q;
      m_wr_d     = m_wr_q;
      wr_op_d    = wr_op_q;
      inv_addr_d = inv_addr_q;
      rdata_d    = rdata_q;
      h_dv       = '0;
      h_inv      = '0;
      h_data_in  = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               g_d      = grant;
               m_addr_d = sel_addr;
               rr_d     = (int'(grant) == N_HARTS - 1) ? '0 : grant + 1'b1;
               if (h_wr[grant]) begin
                  m_data_d = sel_data;
                  m_wr_d   = 1'b1;
                  wr_op_d  = 1'b1;
                  state_d  = S_WR;
               end else begin
                  m_rd_d  = 1'b1;
                  wr_op_d = 1'b0;
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (m_dv) begin
               h_dv[g_q] = 1'b1;
               h_data_in = m_data_in;
               rdata_d   = m_data_in;
               m_rd_d    = 1'b0;
               state_d   = S_DONE;
            end
         end
         S_WR: begin
            if (m_dv) begin
               h_dv[g_q]  = 1'b1;
               m_wr_d     = 1'b0;
               inv_addr_d = m_addr_q;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            // Holding off new grants here lets the hart drop its request.
            if (wr_op_q) h_inv = ~(one_hot_base << g_q);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_idx_d = lock_idx_q;
      if (lock_vld_q) begin
         if (!h_amo_req[lock_idx_q]) lock_vld_d = 1'b0;
      end else if (state_q == S_IDLE && |h_amo_req) begin
         lock_vld_d = 1'b1;
         lock_idx_d = amo_low;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         g_q        <= '0;
         rr_q       <= '0;
         m_addr_q   <= '0;
         m_data_q   <= '0;
         m_rd_q     <= 1'b0;
         m_wr_q     <= 1'b0;
         wr_op_q    <= 1'b0;
         inv_addr_q <= '0;
         rdata_q    <= '0;
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         rr_q       <= rr_d;
         m_addr_q   <= m_addr_d;
         m_data_q   <= m_data_d;
         m_rd_q     <= m_rd_d;
         m_wr_q     <= m_wr_d;
         wr_op_q    <= wr_op_d;
         inv_addr_q <= inv_addr_d;
         rdata_q    <= rdata_d;
         lock_vld_q <= lock_vld_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   assign m_addr      = m_addr_q;
   assign m_rd        = m_rd_q;
   assign m_wr        = m_wr_q;
   assign m_data_out  = m_data_q;
   assign h_inv_addr  = inv_addr_q;
   assign h_amo_ack   = lock_vld_q ? (one_hot_base << lock_idx_q) : '0;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hart_bus_arb.sv
// Directed bench for hart_bus_arb with four harts and a 64-bit line.
module tb_hart_bus_arb;

   localparam int N  = 4;
   localparam int LW = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N*64-1:0]   h_addr;
   logic [N-1:0]      h_rd, h_wr;
   logic [N*LW-1:0]   h_data_out;
   logic [LW-1:0]     h_data_in;
   logic [N-1:0]      h_dv;
   logic [63:0]       h_inv_addr;
   logic [N-1:0]      h_inv;
   logic [N-1:0]      h_amo_req;
   logic [N-1:0]      h_amo_ack;
   logic [63:0]       m_addr;
   logic              m_rd, m_wr;
   logic [LW-1:0]     m_data_out;
   logic [LW-1:0]     m_data_in;
   logic              m_dv;
   logic [1:0]        dbg_state;

   int checks   = 0;
   int failures = 0;

   hart_bus_arb #(.N_HARTS(N), .LINE_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr),
      .h_data_out(h_data_out), .h_data_in(h_data_in), .h_dv(h_dv),
      .h_inv_addr(h_inv_addr), .h_inv(h_inv), .h_amo_req(h_amo_req),
      .h_amo_ack(h_amo_ack), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr),
      .m_data_out(m_data_out), .m_data_in(m_data_in), .m_dv(m_dv),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      h_addr = '0; h_rd = '0; h_wr = '0; h_data_out = '0;
      h_amo_req = '0; m_data_in = '0; m_dv = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_strobe(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (m_rd || m_wr) seen = 1'b1;
         else tick();
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (m_rd !== 1'b0 || m_wr !== 1'b0) begin failures++; $display("FAIL rst_strobes: got rd=%b wr=%b want 0 0", m_rd, m_wr); end
      checks++; if (h_dv !== 4'b0 || h_inv !== 4'b0 || h_amo_ack !== 4'b0) begin failures++; $display("FAIL rst_pulses: got dv=%b inv=%b ack=%b want 0", h_dv, h_inv, h_amo_ack); end
      checks++; if (m_addr !== 64'h0 || m_data_out !== 64'h0 || h_inv_addr !== 64'h0) begin failures++; $display("FAIL rst_regs: got addr=%h data=%h inv=%h want 0", m_addr, m_data_out, h_inv_addr); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
      h_addr[63:0] = 64'h40; h_rd[0] = 1'b1;
      tick();
      checks++; if (m_rd !== 1'b1 || dbg_state !== 2'd1) begin failures++; $display("FAIL rst_pre_rd: got rd=%b st=%0d want 1 1", m_rd, dbg_state); end
      rst_n = 1'b0;
      #1;
      checks++; if (m_rd !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL rst_abort: got rd=%b st=%0d want 0 0", m_rd, dbg_state); end
      tick();
      h_rd = '0; rst_n = 1'b1;
      tick();
      m_dv = 1'b1; m_data_in = 64'h1234;
      #1;
      checks++; if (h_dv !== 4'b0) begin failures++; $display("FAIL rst_stray_dv: got %b want 0000", h_dv); end
      tick();
      m_dv = 1'b0;
      checks++; if (dbg_state !== 2'd0 || m_rd !== 1'b0 || h_data_in !== 64'h0) begin failures++; $display("FAIL rst_after_stray: got st=%0d rd=%b din=%h want 0 0 0", dbg_state, m_rd, h_data_in); end
   endtask

   task automatic test_single_read();
      apply_reset();
      h_addr[63:0] = 64'h8000_0040; h_rd[0] = 1'b1;
      #1;
      checks++; if (m_rd !== 1'b0) begin failures++; $display("FAIL rd_early: got %b want 0", m_rd); end
      tick();
      checks++; if (m_rd !== 1'b1 || m_addr !== 64'h8000_0040) begin failures++; $display("FAIL rd_strobe: got rd=%b addr=%h want 1 80000040", m_rd, m_addr); end
      tick(); tick();
      checks++; if (m_rd !== 1'b1 || h_dv !== 4'b0) begin failures++; $display("FAIL rd_hold: got rd=%b dv=%b want 1 0000", m_rd, h_dv); end
      m_dv = 1'b1; m_data_in = 64'hA5A5_A5A5_A5A5_A5A5;
      #1;
      checks++; if (h_dv !== 4'b0001 || h_data_in !== 64'hA5A5_A5A5_A5A5_A5A5) begin failures++; $display("FAIL rd_dv: got dv=%b din=%h want 0001 a5a5a5a5a5a5a5a5", h_dv, h_data_in); end
      tick();
      m_dv = 1'b0; m_data_in = '0; h_rd = '0;
      #1;
      checks++; if (m_rd !== 1'b0 || h_dv !== 4'b0 || h_inv !== 4'b0 || dbg_state !== 2'd3) begin failures++; $display("FAIL rd_done: got rd=%b dv=%b inv=%b st=%0d want 0 0000 0000 3", m_rd, h_dv, h_inv, dbg_state); end
      tick();
      checks++; if (h_inv !== 4'b0 || dbg_state !== 2'd0 || h_data_in !== 64'hA5A5_A5A5_A5A5_A5A5) begin failures++; $display("FAIL rd_after: got inv=%b st=%0d din=%h want 0000 0 a5a5a5a5a5a5a5a5", h_inv, dbg_state, h_data_in); end
   endtask

   task automatic test_round_robin();
      bit seen;
      int exp;
      logic [63:0] exp_addr;
      logic [N-1:0] exp_dv;
      apply_reset();
      h_addr[63:0] = 64'h100; h_addr[127:64] = 64'h200; h_rd = 4'b0011;
      for (int t = 0; t < 4; t++) begin
         exp = t % 2;
         exp_addr = (exp == 0) ? 64'h100 : 64'h200;
         exp_dv = (exp == 0) ? 4'b0001 : 4'b0010;
         wait_strobe(seen);
         checks++; if (!seen) begin failures++; $display("FAIL rr_timeout: txn %0d got no strobe want strobe", t); end
         checks++; if (m_addr !== exp_addr || m_rd !== 1'b1) begin failures++; $display("FAIL rr_grant: txn %0d got addr=%h rd=%b want %h 1", t, m_addr, m_rd, exp_addr); end
         m_dv = 1'b1; m_data_in = 64'(t);
         #1;
         checks++; if (h_dv !== exp_dv) begin failures++; $display("FAIL rr_dv: txn %0d got %b want %b", t, h_dv, exp_dv); end
         tick();
         m_dv = 1'b0;
      end
      h_rd = '0;
      tick(); tick();
   endtask

   task automatic test_write_inv();
      bit seen;
      apply_reset();
      h_addr[127:64] = 64'h1000; h_data_out[127:64] = 64'hDEAD_BEEF_0123_4567; h_wr[1] = 1'b1;
      wait_strobe(seen);
      checks++; if (!seen) begin failures++; $display("FAIL wr_timeout: got no strobe want strobe"); end
      checks++; if (m_wr !== 1'b1 || m_rd !== 1'b0 || m_addr !== 64'h1000 || m_data_out !== 64'hDEAD_BEEF_0123_4567) begin failures++; $display("FAIL wr_strobe: got wr=%b rd=%b addr=%h data=%h want 1 0 1000 deadbeef01234567", m_wr, m_rd, m_addr, m_data_out); end
      m_dv = 1'b1;
      #1;
      checks++; if (h_dv !== 4'b0010 || h_inv !== 4'b0) begin failures++; $display("FAIL wr_dv: got dv=%b inv=%b want 0010 0000", h_dv, h_inv); end
      tick();
      m_dv = 1'b0; h_wr = '0;
      #1;
      checks++; if (h_inv !== 4'b1101 || h_inv_addr !== 64'h1000 || h_dv !== 4'b0 || m_wr !== 1'b0) begin failures++; $display("FAIL wr_inv: got inv=%b iaddr=%h dv=%b wr=%b want 1101 1000 0000 0", h_inv, h_inv_addr, h_dv, m_wr); end
      tick();
      checks++; if (h_inv !== 4'b0) begin failures++; $display("FAIL wr_inv_pulse: got %b want 0000", h_inv); end
   endtask

   task automatic test_amo_lock();
      bit seen;
      apply_reset();
      h_amo_req[1] = 1'b1;
      #1;
      checks++; if (h_amo_ack !== 4'b0) begin failures++; $display("FAIL amo_early: got %b want 0000", h_amo_ack); end
      tick();
      checks++; if (h_amo_ack !== 4'b0010) begin failures++; $display("FAIL amo_ack: got %b want 0010", h_amo_ack); end
      h_addr[63:0] = 64'h300; h_rd[0] = 1'b1;
      repeat (4) tick();
      checks++; if (m_rd !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL amo_block: got rd=%b st=%0d want 0 0", m_rd, dbg_state); end
      h_addr[127:64] = 64'h2000; h_data_out[127:64] = 64'h77; h_wr[1] = 1'b1;
      wait_strobe(seen);
      checks++; if (!seen || m_wr !== 1'b1 || m_addr !== 64'h2000) begin failures++; $display("FAIL amo_owner: got seen=%b wr=%b addr=%h want 1 1 2000", seen, m_wr, m_addr); end
      m_dv = 1'b1;
      #1;
      checks++; if (h_dv !== 4'b0010) begin failures++; $display("FAIL amo_owner_dv: got %b want 0010", h_dv); end
      tick();
      m_dv = 1'b0; h_wr = '0;
      tick(); tick();
      checks++; if (m_rd !== 1'b0 || h_amo_ack !== 4'b0010) begin failures++; $display("FAIL amo_still_locked: got rd=%b ack=%b want 0 0010", m_rd, h_amo_ack); end
      h_amo_req = '0;
      tick();
      checks++; if (h_amo_ack !== 4'b0 || m_rd !== 1'b0) begin failures++; $display("FAIL amo_release: got ack=%b rd=%b want 0000 0", h_amo_ack, m_rd); end
      tick();
      checks++; if (m_rd !== 1'b1 || m_addr !== 64'h300) begin failures++; $display("FAIL amo_after: got rd=%b addr=%h want 1 300", m_rd, m_addr); end
      m_dv = 1'b1;
      #1;
      checks++; if (h_dv !== 4'b0001) begin failures++; $display("FAIL amo_after_dv: got %b want 0001", h_dv); end
      tick();
      m_dv = 1'b0; h_rd = '0;
      tick();
   endtask

   task automatic test_rw_both();
      bit seen;
      apply_reset();
      h_addr[191:128] = 64'h400; h_data_out[191:128] = 64'h55AA; h_rd[2] = 1'b1; h_wr[2] = 1'b1;
      wait_strobe(seen);
      checks++; if (!seen || m_wr !== 1'b1 || m_rd !== 1'b0 || m_data_out !== 64'h55AA) begin failures++; $display("FAIL both_op: got seen=%b wr=%b rd=%b data=%h want 1 1 0 55aa", seen, m_wr, m_rd, m_data_out); end
      m_dv = 1'b1;
      #1;
      checks++; if (h_dv !== 4'b0100) begin failures++; $display("FAIL both_dv: got %b want 0100", h_dv); end
      tick();
      m_dv = 1'b0; h_rd = '0; h_wr = '0;
      #1;
      checks++; if (h_dv !== 4'b0 || h_inv !== 4'b1011) begin failures++; $display("FAIL both_done: got dv=%b inv=%b want 0000 1011", h_dv, h_inv); end
      tick(); tick();
      checks++; if (m_rd !== 1'b0 || m_wr !== 1'b0 || h_dv !== 4'b0) begin failures++; $display("FAIL both_single: got rd=%b wr=%b dv=%b want 0 0 0000", m_rd, m_wr, h_dv); end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_inv();
      test_amo_lock();
      test_rw_both();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
